// File: rtl/enemy_render_pkg.sv
// ---------------------------------------------------------------------------
// enemy_render_pkg
// Shared definitions for the enemy box renderer:
//   state_t        - renderer FSM encoding (IDLE, ERASE, DRAW, DONE)
//   DEF_BG_COLOUR  - default colour used to erase a box
//   HIDE_COLOUR    - request colour that removes an enemy from the screen
//   SCREEN_X_MAX / SCREEN_Y_MAX - last visible column / row of the VGA frame
//   pix_coord()    - 9-bit pixel address; bit 8 is the carry-out of base+offset
// ---------------------------------------------------------------------------
package enemy_render_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] DEF_BG_COLOUR = 3'b000;
    localparam logic [2:0] HIDE_COLOUR   = 3'b000;
    localparam int         SCREEN_X_MAX  = 159;
    localparam int         SCREEN_Y_MAX  = 119;

    // Carry is kept so that a box wrapping past 255 is seen as off-screen.
    function automatic logic [8:0] pix_coord(input logic [7:0] base,
                                             input logic [2:0] off);
        return {1'b0, base} + {6'b0, off};
    endfunction

endpackage

// File: rtl/enemy_box_renderer_box_scanner.sv
// ---------------------------------------------------------------------------
// box_scanner
// Walks the offsets of a BOX_W x BOX_H box in row-major order (dx fastest),
// starting at (0,0). dx/dy present the offset to be emitted on this clock
// edge, so the caller can register a pixel in the same cycle it asserts start.
// Ports:
//   clock, reset_n  - clock, asynchronous active-low reset
//   start           - begin a new pass; offset (0,0) is presented immediately
//   dx, dy          - offset for the pixel being issued this cycle
//   last            - the offset issued on the previous edge was the final one
// ---------------------------------------------------------------------------
module box_scanner
    import enemy_render_pkg::*;
#(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic [2:0] dx,
    output logic [2:0] dy,
    output logic       last
);

    logic [2:0] r_dx;
    logic [2:0] r_dy;
    logic       r_run;
    logic       w_end_col;
    logic       w_end_box;

    assign w_end_col = (r_dx == 3'(BOX_W - 1));
    assign w_end_box = w_end_col && (r_dy == 3'(BOX_H - 1));
    assign last      = r_run && w_end_box;

    always_comb begin
        dx = r_dx;
        dy = r_dy;
        if (start) begin
            dx = 3'd0;
            dy = 3'd0;
        end else if (r_run) begin
            if (w_end_col) begin
                dx = 3'd0;
                dy = r_dy + 3'd1;
            end else begin
                dx = r_dx + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dx  <= 3'd0;
            r_dy  <= 3'd0;
            r_run <= 1'b0;
        end else begin
            r_dx  <= dx;
            r_dy  <= dy;
            r_run <= start || (r_run && !w_end_box);
        end
    end

endmodule

// File: rtl/enemy_box_renderer.sv
// ---------------------------------------------------------------------------
// enemy_box_renderer
// Accepts per-enemy sprite updates (slot, x, y, colour) over valid/ready and
// turns each into single-pixel writes for the VGA adapter: erase the box at
// the slot's previous position, then draw it at the new one. Colour 3'b000
// hides the enemy (erase only). Off-screen pixels still take a cycle but are
// not plotted.
// Ports:
//   clock, reset_n               - clock, asynchronous active-low reset
//   req_valid / req_ready        - update handshake
//   req_slot, req_x, req_y, req_colour - update payload
//   vga_x, vga_y, vga_colour, vga_plot - registered pixel write to adapter
//   busy                         - erase/draw/commit in progress
// Optional build macro:
//   ENEMY_RENDER_SKIP_SAME_EN - a request identical to the stored slot state
//                               commits with no erase/draw.
// ---------------------------------------------------------------------------
module enemy_box_renderer
    import enemy_render_pkg::*;
#(
    parameter int         NUM_SLOTS = 3,
    parameter int         BOX_W     = 4,
    parameter int         BOX_H     = 4,
    parameter logic [2:0] BG_COLOUR = DEF_BG_COLOUR,
    parameter int         X_MAX     = SCREEN_X_MAX,
    parameter int         Y_MAX     = SCREEN_Y_MAX
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_slot,
    input  logic [7:0] req_x,
    input  logic [7:0] req_y,
    input  logic [2:0] req_colour,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy
);

    localparam logic [8:0] LIM_X = 9'(X_MAX);
    localparam logic [8:0] LIM_Y = 9'(Y_MAX);

    state_t     r_state;
    state_t     w_nx_state;
    logic       r_req_ready;
    logic       r_busy;
    logic [7:0] r_vga_x;
    logic [7:0] r_vga_y;
    logic [2:0] r_vga_colour;
    logic       r_vga_plot;

    // Latched request
    logic [1:0] r_slot;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [2:0] r_colour;

    // Per-slot memory; arrays cover every encodable slot, only the first
    // NUM_SLOTS are ever written.
    logic [3:0] r_slot_vld;
    logic [7:0] r_old_x [0:3];
    logic [7:0] r_old_y [0:3];

    logic       w_start;
    logic       w_last;
    logic [2:0] w_dx;
    logic [2:0] w_dy;
    logic       w_accept;
    logic       w_req_slot_ok;
    logic       w_slot_ok;
    logic [1:0] w_slot_sel;
    logic       w_erase;
    logic [7:0] w_bx;
    logic [7:0] w_by;
    logic [2:0] w_col;
    logic [8:0] w_px;
    logic [8:0] w_py;
    logic       w_plot;

    assign w_accept      = req_valid && r_req_ready;
    assign w_req_slot_ok = (32'(req_slot) < NUM_SLOTS);
    assign w_slot_ok     = (32'(r_slot) < NUM_SLOTS);

`ifdef ENEMY_RENDER_SKIP_SAME_EN
    // Stored colour is only needed to recognise a repeated request.
    logic [2:0] r_old_colour [0:3];
    logic       w_same;

    assign w_same = r_slot_vld[req_slot]
                 && (r_old_x[req_slot] == req_x)
                 && (r_old_y[req_slot] == req_y)
                 && (r_old_colour[req_slot] == req_colour);

    always_ff @(posedge clock) begin
        if (r_state == ST_DONE && w_slot_ok && r_colour != HIDE_COLOUR)
            r_old_colour[r_slot] <= r_colour;
    end
`endif

    box_scanner #(
        .BOX_W (BOX_W),
        .BOX_H (BOX_H)
    ) u_scanner (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (w_start),
        .dx      (w_dx),
        .dy      (w_dy),
        .last    (w_last)
    );

    always_comb begin
        w_nx_state = r_state;
        w_start    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_req_slot_ok) begin
                        w_nx_state = ST_DONE;
`ifdef ENEMY_RENDER_SKIP_SAME_EN
                    end else if (w_same) begin
                        w_nx_state = ST_DONE;
`endif
                    end else if (r_slot_vld[req_slot]) begin
                        w_nx_state = ST_ERASE;
                        w_start    = 1'b1;
                    end else if (req_colour == HIDE_COLOUR) begin
                        // Hiding something never drawn: nothing to do.
                        w_nx_state = ST_DONE;
                    end else begin
                        w_nx_state = ST_DRAW;
                        w_start    = 1'b1;
                    end
                end
            end
            ST_ERASE: begin
                if (w_last) begin
                    if (r_colour == HIDE_COLOUR) begin
                        w_nx_state = ST_DONE;
                    end else begin
                        w_nx_state = ST_DRAW;
                        w_start    = 1'b1;
                    end
                end
            end
            ST_DRAW: begin
                if (w_last) w_nx_state = ST_DONE;
            end
            ST_DONE: w_nx_state = ST_IDLE;
            default: w_nx_state = ST_IDLE;
        endcase
    end

    // The pixel registered this edge belongs to the next state, so in IDLE
    // the request is taken straight from the inputs (not yet latched).
    always_comb begin
        w_slot_sel = (r_state == ST_IDLE) ? req_slot : r_slot;
        w_erase    = (w_nx_state == ST_ERASE);
        if (w_erase) begin
            w_bx  = r_old_x[w_slot_sel];
            w_by  = r_old_y[w_slot_sel];
            w_col = BG_COLOUR;
        end else if (r_state == ST_IDLE) begin
            w_bx  = req_x;
            w_by  = req_y;
            w_col = req_colour;
        end else begin
            w_bx  = r_x;
            w_by  = r_y;
            w_col = r_colour;
        end
        w_px   = pix_coord(w_bx, w_dx);
        w_py   = pix_coord(w_by, w_dy);
        w_plot = (w_erase || w_nx_state == ST_DRAW)
              && (w_px <= LIM_X) && (w_py <= LIM_Y);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_vga_x      <= 8'd0;
            r_vga_y      <= 8'd0;
            r_vga_colour <= 3'd0;
            r_vga_plot   <= 1'b0;
            r_slot_vld   <= 4'd0;
        end else begin
            r_state      <= w_nx_state;
            r_req_ready  <= (w_nx_state == ST_IDLE);
            r_busy       <= (w_nx_state != ST_IDLE);
            r_vga_x      <= w_px[7:0];
            r_vga_y      <= w_py[7:0];
            r_vga_colour <= w_col;
            r_vga_plot   <= w_plot;
            if (r_state == ST_DONE && w_slot_ok)
                r_slot_vld[r_slot] <= (r_colour != HIDE_COLOUR);
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_slot   <= req_slot;
            r_x      <= req_x;
            r_y      <= req_y;
            r_colour <= req_colour;
        end
        if (r_state == ST_DONE && w_slot_ok && r_colour != HIDE_COLOUR) begin
            r_old_x[r_slot] <= r_x;
            r_old_y[r_slot] <= r_y;
        end
    end

    assign req_ready  = r_req_ready;
    assign busy       = r_busy;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;

endmodule
